// File: rtl/xbar_master_port.sv
`default_nettype none
// ============================================================================
// Module : xbar_master_port
// Master-side crossbar input stage: FIFO buffering, slave decode from an
// address bit, and request/grant/ack sequencing toward the per-slave arbiters.
// Rev    : 1.0
// ============================================================================
module xbar_master_port #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 4,
  parameter int SEL_BIT = ADDR_W - 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic              m_write,
  output logic [1:0]        request,
  input  logic [1:0]        grant,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_write,
  input  logic [1:0]        s_ack,
  output logic              err
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  // FIFO storage and pointers
  logic [ADDR_W-1:0]  addr_q  [DEPTH];
  logic [DATA_W-1:0]  wdata_q [DEPTH];
  logic [DEPTH-1:0]   write_q;
  logic [DEPTH-1:0]   tgt_q;
  logic [c_ptr_w-1:0] wr_ptr_q;
  logic [c_ptr_w-1:0] rd_ptr_q;
  logic [c_cnt_w-1:0] count_q;

  state_t      state_q, state_d;
  logic [1:0]  request_q, request_d;
  logic        s_valid_q, s_valid_d;
  logic        err_q, err_d;

  logic        w_push;
  logic        w_pop;
  logic        w_head_tgt;
  logic        w_other_tgt;
  logic [1:0]  w_tgt_onehot;
  logic        w_grant_err;
  logic        w_ack_err;

  assign m_ready      = (count_q != c_full);
  assign w_push       = m_valid && m_ready;
  assign w_head_tgt   = tgt_q[rd_ptr_q];
  assign w_other_tgt  = ~w_head_tgt;
  assign w_tgt_onehot = w_head_tgt ? 2'b10 : 2'b01;
  assign w_pop        = (state_q == XFER) && s_ack[w_head_tgt];

  assign s_addr  = addr_q[rd_ptr_q];
  assign s_wdata = wdata_q[rd_ptr_q];
  assign s_write = write_q[rd_ptr_q];
  assign request = request_q;
  assign s_valid = s_valid_q;
  assign err     = err_q;

  // Payload storage needs no reset; contents are qualified by count_q.
  always_ff @(posedge clock) begin
    if (w_push) begin
      addr_q[wr_ptr_q]  <= m_addr;
      wdata_q[wr_ptr_q] <= m_wdata;
      write_q[wr_ptr_q] <= m_write;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tgt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        tgt_q[wr_ptr_q] <= m_addr[SEL_BIT];
        wr_ptr_q        <= wr_ptr_q + c_ptr_w'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + c_cnt_w'(1);
        2'b01:   count_q <= count_q - c_cnt_w'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Misdirected grant/ack bits only raise the sticky flag; they never steer the FSM.
  assign w_grant_err = ((state_q == REQ) || (state_q == XFER)) && grant[w_other_tgt];
  assign w_ack_err   = ((s_ack != 2'b00) && (state_q != XFER)) || s_ack[w_other_tgt];

  always_comb begin
    state_d   = state_q;
    request_d = request_q;
    s_valid_d = s_valid_q;
    err_d     = err_q | w_grant_err | w_ack_err;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d   = REQ;
          request_d = w_tgt_onehot;
        end
      end
      REQ: begin
        if (grant[w_head_tgt]) begin
          state_d   = XFER;
          s_valid_d = 1'b1;
        end
      end
      XFER: begin
        // Always fall back to IDLE so the arbiter sees a request gap.
        if (s_ack[w_head_tgt]) begin
          state_d   = IDLE;
          request_d = 2'b00;
          s_valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        request_d = 2'b00;
        s_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      request_q <= 2'b00;
      s_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      request_q <= request_d;
      s_valid_q <= s_valid_d;
      err_q     <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xbar_master_port.sv
`default_nettype none
// tb_xbar_master_port: scoreboard bench; a transaction-level queue model predicts
// slave-side presentation order, target decode and FIFO back-pressure.
module tb_xbar_master_port;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wr;
    logic              tgt;
  } txn_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              m_valid = 1'b0;
  logic              m_ready;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic              m_write = 1'b0;
  logic [1:0]        request;
  logic [1:0]        grant = 2'b00;
  logic              s_valid;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_write;
  logic [1:0]        s_ack = 2'b00;
  logic              err;

  txn_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  int         mode = 0;
  logic [1:0] dir_grant = 2'b00;
  logic [1:0] dir_ack = 2'b00;

  xbar_master_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .SEL_BIT(ADDR_W - 1)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_write(m_write),
    .request(request),
    .grant  (grant),
    .s_valid(s_valid),
    .s_addr (s_addr),
    .s_wdata(s_wdata),
    .s_write(s_write),
    .s_ack  (s_ack),
    .err    (err)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] onehot(input logic t);
    return t ? 2'b10 : 2'b01;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offers one transaction for up to 'tries' cycles; acceptance comes from the model.
  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic w, input int tries, output bit ok);
    txn_t t;
    ok = 1'b0;
    m_valid = 1'b1;
    m_addr  = a;
    m_wdata = d;
    m_write = w;
    for (int k = 0; k < tries && !ok; k++) begin
      check("m_ready", m_ready, exp_q.size() != DEPTH);
      if (exp_q.size() != DEPTH) begin
        t.addr = a;
        t.data = d;
        t.wr   = w;
        t.tgt  = a[ADDR_W-1];
        exp_q.push_back(t);
        ok = 1'b1;
      end
      tick();
    end
    m_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || request != 2'b00) && n < 400) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 400) begin
      fails++;
      $display("FAIL %s: drain timeout, got %0d entries left expected 0", name, exp_q.size());
    end
  endtask

  // Slave/arbiter responder: the only driver of grant and s_ack.
  initial begin
    forever begin
      @(posedge clock);
      #2;
      case (mode)
        0: begin
          grant = dir_grant;
          s_ack = dir_ack;
        end
        1: begin
          grant = s_valid ? 2'b00 : request;
          s_ack = s_valid ? request : 2'b00;
        end
        default: begin
          grant = ($urandom_range(0, 2) != 0) ? request : 2'b00;
          s_ack = (s_valid && ($urandom_range(0, 2) != 0)) ? request : 2'b00;
        end
      endcase
    end
  end

  // Monitor: compares the presented head against the model on every completing edge.
  initial begin : monitor
    txn_t h;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (request != 2'b00) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL req_no_txn: got request=%b expected 00 with empty model", request);
          end else begin
            check("request_target", request, onehot(exp_q[0].tgt));
          end
        end
        if (s_valid && exp_q.size() != 0 && s_ack[exp_q[0].tgt]) begin
          h = exp_q.pop_front();
          check("s_addr", s_addr, h.addr);
          check("s_wdata", s_wdata, h.data);
          check("s_write", s_write, h.wr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    logic [1:0] seq [6];
    seq = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};

    // Reset and idle
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("idle_request", request, 2'b00);
      check("idle_s_valid", s_valid, 1'b0);
      check("idle_m_ready", m_ready, 1'b1);
      check("idle_err", err, 1'b0);
      tick();
    end

    // Single transaction to slave 1
    push(32'h8000_0010, 32'hA5A5_A5A5, 1'b1, 1, ok);
    check("single_req_e0", request, 2'b00);
    tick();
    check("single_req_e1", request, 2'b10);
    check("single_sv_e1", s_valid, 1'b0);
    dir_grant = 2'b10;
    tick();
    dir_grant = 2'b00;
    check("single_sv_e2", s_valid, 1'b1);
    check("single_saddr_e2", s_addr, 32'h8000_0010);
    check("single_req_e2", request, 2'b10);
    dir_ack = 2'b10;
    tick();
    dir_ack = 2'b00;
    check("single_sv_done", s_valid, 1'b0);
    check("single_req_done", request, 2'b00);
    check("single_ready_done", m_ready, 1'b1);
    tick();
    check("single_req_after", request, 2'b00);

    // Back-to-back, different targets
    mode = 1;
    push(32'h0000_0004, 32'h1111_0004, 1'b0, 1, ok);
    push(32'h8000_0008, 32'h2222_0008, 1'b1, 1, ok);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("b2b_req%0d", i), request, seq[i]);
      tick();
    end
    wait_idle("b2b_drain");

    // FIFO full
    mode = 0;
    for (int i = 1; i <= 4; i++) begin
      push(32'(i * 16), 32'hC0DE_0000 + 32'(i), 1'b1, 1, ok);
    end
    check("full_m_ready", m_ready, 1'b0);
    push(32'h0000_0050, 32'hC0DE_0005, 1'b0, 1, ok);
    check("full_still_blocked", m_ready, 1'b0);
    mode = 1;
    push(32'h0000_0050, 32'hC0DE_0005, 1'b0, 50, ok);
    check("full_fifth_accepted", ok, 1'b1);
    wait_idle("full_drain");

    // Protocol error: wrong-slave grant while requesting slave 0
    mode = 0;
    push(32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 1, ok);
    tick();
    check("perr_req", request, 2'b01);
    dir_grant = 2'b10;
    tick();
    check("perr_err_set", err, 1'b1);
    check("perr_req_held", request, 2'b01);
    check("perr_no_xfer", s_valid, 1'b0);
    dir_grant = 2'b01;
    tick();
    dir_grant = 2'b00;
    check("perr_xfer", s_valid, 1'b1);
    dir_ack = 2'b01;
    tick();
    dir_ack = 2'b00;
    check("perr_done_sv", s_valid, 1'b0);
    check("perr_done_req", request, 2'b00);
    check("perr_sticky", err, 1'b1);

    // Reset mid-transfer
    push(32'h8000_1000, 32'h0000_0001, 1'b1, 1, ok);
    push(32'h8000_2000, 32'h0000_0002, 1'b0, 1, ok);
    push(32'h8000_3000, 32'h0000_0003, 1'b1, 1, ok);
    dir_grant = 2'b10;
    tick();
    dir_grant = 2'b00;
    check("rst_in_xfer", s_valid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("rst_req", request, 2'b00);
    check("rst_sv", s_valid, 1'b0);
    check("rst_m_ready", m_ready, 1'b1);
    check("rst_err", err, 1'b0);
    tick();
    check("rst_empty_req", request, 2'b00);
    mode = 1;
    push(32'h0000_0200, 32'h5555_AAAA, 1'b1, 1, ok);
    wait_idle("rst_new_push");

    // Randomized traffic against the queue model
    mode = 2;
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      push($urandom, $urandom, 1'($urandom_range(0, 1)), 300, ok);
      check("rand_accept", ok, 1'b1);
    end
    wait_idle("rand_drain");
    check("rand_no_err", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
